alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the ALU top level and feeds it.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU's A/B/ALU_FUN inputs.
- Captures the registered result and flag of the unit selected by ALU_FUN[3:2], and presents it as a single response stream with valid/ready.

Parameters:
- DATA_WIDTH, 16, width of operands A/B and of the result bus.
- FUN_WIDTH, 4, ALU function code width; [3:2] selects the unit, [1:0] selects the operation.
- CMP_WIDTH, 4, width of the compare-unit output.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  single clock for the block and the ALU it drives.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  FIFO can accept; equals "not full".
- CMD_A  in  DATA_WIDTH  operand A.
- CMD_B  in  DATA_WIDTH  operand B.
- CMD_FUN  in  FUN_WIDTH  ALU function code.
- ALU_A  out  DATA_WIDTH  registered operand A to the ALU.
- ALU_B  out  DATA_WIDTH  registered operand B to the ALU.
- ALU_FUN  out  FUN_WIDTH  registered function code to the ALU.
- ALU_RST  out  1  drives all four ALU unit resets; equals RST OR'd with the one-cycle flush pulse.
- ARITH_OUT, LOGIC_OUT, SHIFT_OUT  in  DATA_WIDTH  ALU unit results.
- CMP_OUT  in  CMP_WIDTH  compare result.
- ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, CARRY_OUT  in  1  ALU flags and carry.
- RES_VALID  out  1  response held.
- RES_READY  in  1  consumer accepts the response.
- RES_DATA  out  DATA_WIDTH  captured result; CMP_OUT is zero-extended.
- RES_CARRY  out  1  CARRY_OUT when unit = arith, else 0.
- RES_UNIT  out  2  copy of FUN[3:2] of the issued command.
- RES_ERR  out  1  selected unit flag was low at capture.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge):
  - FIFO emptied; FSM to IDLE.
  - ALU_A, ALU_B, ALU_FUN, RES_* all 0; RES_VALID=0; CMD_READY=1 on the first cycle after reset.
  - ALU_RST=1 while RST=1.
- FIFO:
  - A push occurs on a CLK edge when CMD_VALID and CMD_READY are both high.
  - A pop occurs on the edge leaving IDLE.
  - Simultaneous push and pop is allowed: count is unchanged, data ordering is preserved.
  - When full, CMD_READY=0 and CMD_VALID is ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if the FIFO is non-empty, load ALU_A/ALU_B/ALU_FUN from the head, pop, go to ISSUE. Otherwise hold ALU_* unchanged.
  - ISSUE: ALU_* are stable; the ALU registers its output on this cycle's closing edge. Go to CAPTURE.
  - CAPTURE: mux on ALU_FUN[3:2].
    - 00 = ARITH_OUT/ARITH_FLAG
    - 01 = LOGIC_OUT/LOGIC_FLAG
    - 10 = CMP_OUT/CMP_FLAG
    - 11 = SHIFT_OUT/SHIFT_FLAG
    - Register RES_DATA, RES_CARRY, RES_UNIT, and RES_ERR = !flag.
    - Set RES_VALID=1 and go to RESP.
  - RESP: hold all RES_* stable while RES_READY=0. On an edge with RES_READY=1, clear RES_VALID. Then go to ISSUE if the FIFO is non-empty (loading and popping the next command on that same edge), else go to IDLE.
- Latency and throughput:
  - Minimum latency from the command accept edge (empty FIFO, IDLE) to RES_VALID high is 3 edges.
  - Back-to-back throughput is one response per 3 cycles with RES_READY held high.
- ALU_* remain unchanged in CAPTURE and RESP. A new command never perturbs an in-flight result.
- Response ordering is strictly FIFO order.
- Reset mid-operation (any state): the in-flight command and all queued commands are dropped, with no partial response. RES_VALID falls in the cycle after the reset edge.

Decomposition:
- Shared package alu_seq_pkg:
  - Unit-select constants UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11.
  - FSM state encoding.
  - Default widths.
- One sub-module: alu_cmd_fifo, a synchronous FIFO with push/pop/full/empty/count. The FSM, result mux and response register live in the top.

Test Plan:
- Reset, then push {A=0x0005, B=0x0003, FUN=4'b0000}, with a stub ALU returning ARITH_OUT=0x0008 and ARITH_FLAG=1 one edge after ISSUE -> RES_VALID at accept+3 edges; RES_DATA=0x0008, RES_UNIT=0, RES_ERR=0, RES_CARRY=0.
- Push {A=0xFFFF, B=0x0001, FUN=0000} with the stub returning 0x0000 and carry=1 -> RES_DATA=0x0000, RES_CARRY=1. Then a logic command (FUN=0100) with CARRY_OUT=1 on the stub -> RES_CARRY=0.
- Compare command FUN=4'b1000 with CMP_OUT=4'b0011 -> RES_DATA=0x0003, RES_UNIT=2; with CMP_FLAG forced 0 -> RES_ERR=1.
- Hold RES_READY=0 and push 6 commands -> first 4 accepted after the in-flight one (1 in flight + 4 queued), CMD_READY=0 while full. Release RES_READY -> responses arrive in push order and RES_* are stable during the stall.
- Assert RST for one cycle while in CAPTURE with 2 commands queued -> RES_VALID=0, CMD_READY=1, ALU_FUN=0, ALU_RST=1 for that cycle, and no stale response afterwards.
- Push one command on the same edge that RESP completes with the FIFO full-1 -> no command lost or duplicated; FIFO count is correct.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU command sequencer: default widths,
// unit-select codes (ALU_FUN[3:2]) and the sequencer FSM encoding.
package alu_seq_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FUN_WIDTH  = 4;
  localparam int DEF_CMP_WIDTH  = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO. Head entry is visible combinationally so the
// sequencer can load it on the same edge that pops it.
module alu_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the ALU: queues commands, issues one at a time, and
// returns the selected unit's registered result as a valid/ready response.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FUN_WIDTH  = DEF_FUN_WIDTH,
  parameter int CMP_WIDTH  = DEF_CMP_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [DATA_WIDTH-1:0] CMD_A,
  input  logic [DATA_WIDTH-1:0] CMD_B,
  input  logic [FUN_WIDTH-1:0]  CMD_FUN,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_RST,
  input  logic [DATA_WIDTH-1:0] ARITH_OUT,
  input  logic [DATA_WIDTH-1:0] LOGIC_OUT,
  input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
  input  logic [CMP_WIDTH-1:0]  CMP_OUT,
  input  logic                  ARITH_FLAG,
  input  logic                  LOGIC_FLAG,
  input  logic                  CMP_FLAG,
  input  logic                  SHIFT_FLAG,
  input  logic                  CARRY_OUT,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [DATA_WIDTH-1:0] RES_DATA,
  output logic                  RES_CARRY,
  output logic [1:0]            RES_UNIT,
  output logic                  RES_ERR
);

  localparam int CMD_W = 2*DATA_WIDTH + FUN_WIDTH;

  seq_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [FUN_WIDTH-1:0]  r_alu_fun;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_carry;
  logic [1:0]            r_res_unit;
  logic                  r_res_err;
  logic                  r_flush;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_load;
  logic [CMD_W-1:0]      w_head;
  logic [1:0]            w_unit;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_flag;

  assign w_push = CMD_VALID && !w_full;
  // A head entry is consumed whenever the FSM is free to start the next command.
  assign w_load = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_RESP && RES_READY));

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_wdata ({CMD_A, CMD_B, CMD_FUN}),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_unit = r_alu_fun[3:2];

  always_comb begin
    w_sel_data = ARITH_OUT;
    w_sel_flag = ARITH_FLAG;
    case (w_unit)
      UNIT_LOGIC: begin
        w_sel_data = LOGIC_OUT;
        w_sel_flag = LOGIC_FLAG;
      end
      UNIT_CMP: begin
        w_sel_data = DATA_WIDTH'(CMP_OUT);
        w_sel_flag = CMP_FLAG;
      end
      UNIT_SHIFT: begin
        w_sel_data = SHIFT_OUT;
        w_sel_flag = SHIFT_FLAG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_unit  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            {r_alu_a, r_alu_b, r_alu_fun} <= w_head;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_res_data  <= w_sel_data;
          r_res_carry <= (w_unit == UNIT_ARITH) && CARRY_OUT;
          r_res_unit  <= w_unit;
          r_res_err   <= !w_sel_flag;
          r_res_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
            if (w_load) begin
              {r_alu_a, r_alu_b, r_alu_fun} <= w_head;
              r_state <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stretch the ALU reset one cycle past RST so unit output registers are clean.
  always_ff @(posedge CLK) begin
    r_flush <= RST;
  end

  assign ALU_RST   = RST | r_flush;
  assign CMD_READY = !w_full;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign RES_VALID = r_res_valid;
  assign RES_DATA  = r_res_data;
  assign RES_CARRY = r_res_carry;
  assign RES_UNIT  = r_res_unit;
  assign RES_ERR   = r_res_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: stub ALU with registered outputs, directed
// scenarios, then random traffic scored against a queue-based response model.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        RST, CMD_VALID, CMD_READY, ALU_RST, RES_VALID, RES_READY;
  logic [15:0] CMD_A, CMD_B, ALU_A, ALU_B, ARITH_OUT, LOGIC_OUT, SHIFT_OUT, RES_DATA;
  logic [3:0]  CMD_FUN, ALU_FUN, CMP_OUT;
  logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, CARRY_OUT, RES_CARRY, RES_ERR;
  logic [1:0]  RES_UNIT;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [19:0] model_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer dut (
    .CLK(clk), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_RST(ALU_RST),
    .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .SHIFT_OUT(SHIFT_OUT), .CMP_OUT(CMP_OUT),
    .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG),
    .SHIFT_FLAG(SHIFT_FLAG), .CARRY_OUT(CARRY_OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_CARRY(RES_CARRY), .RES_UNIT(RES_UNIT), .RES_ERR(RES_ERR)
  );

  // Stub ALU unit behaviour
  function automatic logic [16:0] f_arith(input logic [15:0] a, b, input logic [1:0] op);
    return (op == 2'd1) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction
  function automatic logic [15:0] f_logic(input logic [15:0] a, b, input logic [1:0] op);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction
  function automatic logic [3:0] f_cmp(input logic [15:0] a, b);
    return a[3:0] + b[3:0];
  endfunction
  function automatic logic [15:0] f_shift(input logic [15:0] a, b, input logic [1:0] op);
    case (op)
      2'd0: return a >> 1;
      2'd1: return a << 1;
      2'd2: return a >> b[3:0];
      default: return a << b[3:0];
    endcase
  endfunction
  function automatic logic f_flag(input logic [15:0] a, b, input int unit);
    case (unit)
      0: return !(a[15] && b[15]);
      1: return !(a[14] && b[14]);
      2: return !(a[15] && b[15]);
      default: return !(a[13] && b[13]);
    endcase
  endfunction

  always @(posedge clk) begin
    if (ALU_RST) begin
      {CARRY_OUT, ARITH_OUT} <= '0;
      LOGIC_OUT <= '0; CMP_OUT <= '0; SHIFT_OUT <= '0;
      ARITH_FLAG <= 1'b0; LOGIC_FLAG <= 1'b0; CMP_FLAG <= 1'b0; SHIFT_FLAG <= 1'b0;
    end else begin
      {CARRY_OUT, ARITH_OUT} <= f_arith(ALU_A, ALU_B, ALU_FUN[1:0]);
      LOGIC_OUT  <= f_logic(ALU_A, ALU_B, ALU_FUN[1:0]);
      CMP_OUT    <= f_cmp(ALU_A, ALU_B);
      SHIFT_OUT  <= f_shift(ALU_A, ALU_B, ALU_FUN[1:0]);
      ARITH_FLAG <= f_flag(ALU_A, ALU_B, 0);
      LOGIC_FLAG <= f_flag(ALU_A, ALU_B, 1);
      CMP_FLAG   <= f_flag(ALU_A, ALU_B, 2);
      SHIFT_FLAG <= f_flag(ALU_A, ALU_B, 3);
    end
  end

  // Expected response {data, carry, unit, err} for one command
  function automatic logic [19:0] exp_resp(input logic [15:0] a, b, input logic [3:0] f);
    logic [16:0] ar;
    logic [15:0] data;
    logic        carry;
    int          u;
    u     = int'(f[3:2]);
    ar    = f_arith(a, b, f[1:0]);
    carry = 1'b0;
    case (u)
      0: begin data = ar[15:0]; carry = ar[16]; end
      1: data = f_logic(a, b, f[1:0]);
      2: data = {12'h000, f_cmp(a, b)};
      default: data = f_shift(a, b, f[1:0]);
    endcase
    return {data, carry, f[3:2], !f_flag(a, b, u)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: at each negedge, the handshakes seen are the ones the next edge takes
  always @(negedge clk) begin
    if (RST) begin
      model_q.delete();
    end else begin
      if (RES_VALID) begin
        if (model_q.size() == 0) check_eq("orphan_resp", 32'(RES_VALID), 32'd0);
        else begin
          check_eq("resp", 32'({RES_DATA, RES_CARRY, RES_UNIT, RES_ERR}), 32'(model_q[0]));
          if (RES_READY) begin
            $display("resp data=%h carry=%0d unit=%0d err=%0d", RES_DATA, RES_CARRY, RES_UNIT, RES_ERR);
            void'(model_q.pop_front());
          end
        end
      end
      if (CMD_VALID && CMD_READY) model_q.push_back(exp_resp(CMD_A, CMD_B, CMD_FUN));
    end
  end

  // Call at posedge+#1; returns at accept-edge+#1 (or after max_wait edges)
  task automatic push_cmd(input logic [15:0] a, b, input logic [3:0] f, input int max_wait, output bit ok);
    CMD_A = a; CMD_B = b; CMD_FUN = f; CMD_VALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (CMD_READY) ok = 1'b1;
      @(posedge clk); #1;
    end
    CMD_VALID = 1'b0;
    if (ok) $display("cmd  a=%h b=%h fun=%b", a, b, f);
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (RES_VALID) return;
    end
    check_eq(tag, 32'(RES_VALID), 32'd1);
  endtask

  task automatic drain(input string tag);
    RES_READY = 1'b1; CMD_VALID = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (model_q.size() == 0 && !RES_VALID) break;
    end
    check_eq(tag, 32'(model_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k, n_acc;
    logic [15:0] ra, rb;
    RST = 1'b1; CMD_VALID = 1'b0; RES_READY = 1'b1;
    CMD_A = '0; CMD_B = '0; CMD_FUN = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_alu_rst", 32'(ALU_RST), 32'd1);
    @(posedge clk); #1; RST = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check_eq("rst_res_valid", 32'(RES_VALID), 32'd0);
    check_eq("rst_alu_regs", 32'({ALU_A, ALU_B, ALU_FUN}), 32'd0);
    check_eq("rst_res_regs", 32'({RES_DATA, RES_CARRY, RES_UNIT, RES_ERR}), 32'd0);
    @(posedge clk); #1;

    // Basic add, latency from accept to RES_VALID
    push_cmd(16'h0005, 16'h0003, 4'b0000, 4, ok);
    k = cyc;
    wait_valid("t1_valid", 10);
    check_eq("t1_latency", 32'(cyc - k), 32'd3);
    check_eq("t1_data", 32'(RES_DATA), 32'h0008);
    check_eq("t1_flags", 32'({RES_CARRY, RES_UNIT, RES_ERR}), 32'd0);
    @(posedge clk); #1;

    // Carry out only reported for the arithmetic unit
    push_cmd(16'hFFFF, 16'h0001, 4'b0000, 4, ok);
    wait_valid("t2_valid", 10);
    check_eq("t2_data", 32'(RES_DATA), 32'h0000);
    check_eq("t2_carry", 32'(RES_CARRY), 32'd1);
    @(posedge clk); #1;
    push_cmd(16'hFFFF, 16'h0001, 4'b0100, 4, ok);
    wait_valid("t2l_valid", 10);
    check_eq("t2l_carry", 32'(RES_CARRY), 32'd0);
    check_eq("t2l_unit", 32'(RES_UNIT), 32'd1);
    @(posedge clk); #1;

    // Compare unit: zero-extended result, error when flag low
    push_cmd(16'h0001, 16'h0002, 4'b1000, 4, ok);
    wait_valid("t3_valid", 10);
    check_eq("t3_data", 32'(RES_DATA), 32'h0003);
    check_eq("t3_unit", 32'(RES_UNIT), 32'd2);
    check_eq("t3_err0", 32'(RES_ERR), 32'd0);
    @(posedge clk); #1;
    push_cmd(16'h8001, 16'h8002, 4'b1000, 4, ok);
    wait_valid("t3e_valid", 10);
    check_eq("t3e_data", 32'(RES_DATA), 32'h0003);
    check_eq("t3e_err1", 32'(RES_ERR), 32'd1);
    drain("t3_drain");

    // Stall: one in flight plus four queued, sixth blocked
    RES_READY = 1'b0; n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(16'(i * 16'h1111), 16'(i + 1), 4'(i * 5), 4, ok);
      n_acc += int'(ok);
    end
    check_eq("t4_accepted", 32'(n_acc), 32'd5);
    push_cmd(16'hABCD, 16'h0007, 4'b1111, 8, ok);
    check_eq("t4_blocked", 32'(ok), 32'd0);
    @(negedge clk);
    check_eq("t4_full_ready", 32'(CMD_READY), 32'd0);
    @(posedge clk); #1;
    RES_READY = 1'b1;
    push_cmd(16'hABCD, 16'h0007, 4'b1111, 20, ok);
    check_eq("t4_late_accept", 32'(ok), 32'd1);
    drain("t4_drain");

    // Push on the same edge a response completes, FIFO at depth-1
    RES_READY = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(16'h0100 + 16'(i), 16'h0010, 4'(4 * i + 1), 4, ok);
    wait_valid("t6_valid", 10);
    @(posedge clk); #1;
    CMD_A = 16'h4444; CMD_B = 16'h0002; CMD_FUN = 4'b1110; CMD_VALID = 1'b1; RES_READY = 1'b1;
    @(negedge clk);
    check_eq("t6_simul_ready", 32'(CMD_READY), 32'd1);
    @(posedge clk); #1;
    CMD_VALID = 1'b0; RES_READY = 1'b0;
    push_cmd(16'h5555, 16'h0003, 4'b0010, 4, ok);
    check_eq("t6_fill_accept", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("t6_full_ready", 32'(CMD_READY), 32'd0);
    @(posedge clk); #1;
    drain("t6_drain");
    repeat (2) @(posedge clk);
    #1;

    // Reset while the first command is in CAPTURE with two queued
    push_cmd(16'h0009, 16'h0004, 4'b0110, 4, ok);
    push_cmd(16'h0001, 16'h0001, 4'b0000, 4, ok);
    push_cmd(16'h0002, 16'h0002, 4'b1100, 4, ok);
    RST = 1'b1;
    @(negedge clk);
    check_eq("t5_alu_rst", 32'(ALU_RST), 32'd1);
    check_eq("t5_fun_issued", 32'(ALU_FUN), 32'b0110);
    @(posedge clk); #1; RST = 1'b0;
    @(negedge clk);
    check_eq("t5_res_valid", 32'(RES_VALID), 32'd0);
    check_eq("t5_cmd_ready", 32'(CMD_READY), 32'd1);
    check_eq("t5_alu_fun", 32'(ALU_FUN), 32'd0);
    repeat (15) @(negedge clk);
    check_eq("t5_no_stale", 32'(RES_VALID), 32'd0);
    @(posedge clk); #1;

    // Random traffic against the model
    CMD_VALID = 1'b0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!CMD_VALID || ok) begin
        ra = 16'($urandom); rb = 16'($urandom);
        CMD_A = ra; CMD_B = rb; CMD_FUN = 4'($urandom);
        CMD_VALID = ($urandom_range(0, 9) < 7);
      end
      RES_READY = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      ok = CMD_VALID && CMD_READY;
      if (ok) $display("cmd  a=%h b=%h fun=%b", CMD_A, CMD_B, CMD_FUN);
      @(posedge clk); #1;
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
